usb_sie_phase_ctrl: RTL and testbench

USB_SIE_PHASE_CTRL -- requirements
Module: usb_sie_phase_ctrl

---
 rtl/usb_sie_phase_ctrl.sv | 147 ++++++++++++++
 tb/tb_usb_sie_phase_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_sie_phase_ctrl.sv
// usb_sie_phase_ctrl: sequences USB SIE receive/transmit phases for a device.
//   clk48_i            48 MHz clock, rising edge
//   rst_n_i            asynchronous active-low reset
//   sendReq_i          protocol layer wants to send one packet (held until sendAck_o)
//   expectResponse_i   host response follows this packet (sampled with sendAck_o)
//   sendAck_o          pulse: request accepted, TX handshake started
//   sendDone_o         pulse: packet fully transmitted
//   sendAborted_o      pulse: TX phase aborted by USB reset
//   responseTimeout_o  pulse: no host response in time
//   rxPacketDone_o     pulse: last RX byte consumed
//   isSendingPhase_o   to SIE isSendingPhase_i
//   txReqSendPacket_o  to SIE txReqSendPacket_i
//   txDoneSending_i    SIE TX completion pulse
//   rxDataValid_i, rxIsLastByte_i, rxAcceptNewData_i  SIE RX handshake (monitored)
//   usbResetDetected_i SIE USB reset flag
//   ackUsbResetDetect_o acknowledge to the SIE
//   state_o            current FSM state, for debug
module usb_sie_phase_ctrl #(
    parameter int TX_GAP_CYCLES       = 8,
    parameter int RESP_TIMEOUT_CYCLES = 72
) (
    input  logic       clk48_i,
    input  logic       rst_n_i,
    input  logic       sendReq_i,
    input  logic       expectResponse_i,
    output logic       sendAck_o,
    output logic       sendDone_o,
    output logic       sendAborted_o,
    output logic       responseTimeout_o,
    output logic       rxPacketDone_o,
    output logic       isSendingPhase_o,
    output logic       txReqSendPacket_o,
    input  logic       txDoneSending_i,
    input  logic       rxDataValid_i,
    input  logic       rxIsLastByte_i,
    input  logic       rxAcceptNewData_i,
    input  logic       usbResetDetected_i,
    output logic       ackUsbResetDetect_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_ACTIVE = 3'd1,
        TX_GAP    = 3'd2,
        TX_REQ    = 3'd3,
        TX_ACTIVE = 3'd4,
        WAIT_RESP = 3'd5,
        USB_RST   = 3'd6
    } state_t;

    localparam logic [7:0] GAP_LAST  = 8'(TX_GAP_CYCLES - 1);
    localparam logic [7:0] RESP_LAST = 8'(RESP_TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       expectLatched;
    logic       rxLastHs;
    logic       inTx;

    assign rxLastHs = rxDataValid_i & rxAcceptNewData_i & rxIsLastByte_i;
    assign inTx     = (state == TX_GAP) || (state == TX_REQ) || (state == TX_ACTIVE);
    assign state_o  = state;

    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= RX_IDLE;
            cnt                 <= 8'd0;
            expectLatched       <= 1'b0;
            sendAck_o           <= 1'b0;
            sendDone_o          <= 1'b0;
            sendAborted_o       <= 1'b0;
            responseTimeout_o   <= 1'b0;
            rxPacketDone_o      <= 1'b0;
            isSendingPhase_o    <= 1'b0;
            txReqSendPacket_o   <= 1'b0;
            ackUsbResetDetect_o <= 1'b0;
        end else begin
            sendAck_o           <= 1'b0;
            sendDone_o          <= 1'b0;
            sendAborted_o       <= 1'b0;
            responseTimeout_o   <= 1'b0;
            rxPacketDone_o      <= 1'b0;
            txReqSendPacket_o   <= 1'b0;
            ackUsbResetDetect_o <= 1'b0;
            if (usbResetDetected_i) begin
                // USB reset overrides everything; acknowledge/abort only on entry
                state            <= USB_RST;
                isSendingPhase_o <= 1'b0;
                if (state != USB_RST) begin
                    ackUsbResetDetect_o <= 1'b1;
                    sendAborted_o       <= inTx;
                end
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (rxDataValid_i) begin
                            state <= RX_ACTIVE;
                        end else if (sendReq_i) begin
                            state            <= TX_GAP;
                            cnt              <= 8'd0;
                            isSendingPhase_o <= 1'b1;
                        end
                    end
                    RX_ACTIVE: begin
                        if (rxLastHs) begin
                            state          <= RX_IDLE;
                            rxPacketDone_o <= 1'b1;
                        end
                    end
                    TX_GAP: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == GAP_LAST) begin
                            state             <= TX_REQ;
                            sendAck_o         <= 1'b1;
                            txReqSendPacket_o <= 1'b1;
                        end
                    end
                    TX_REQ: begin
                        // expectResponse_i is valid while sendAck_o is high
                        state         <= TX_ACTIVE;
                        expectLatched <= expectResponse_i;
                    end
                    TX_ACTIVE: begin
                        if (txDoneSending_i) begin
                            sendDone_o       <= 1'b1;
                            isSendingPhase_o <= 1'b0;
                            cnt              <= 8'd0;
                            state            <= expectLatched ? WAIT_RESP : RX_IDLE;
                        end
                    end
                    WAIT_RESP: begin
                        cnt <= cnt + 8'd1;
                        // a response arriving on the terminal cycle still wins
                        if (rxDataValid_i) begin
                            state <= RX_ACTIVE;
                        end else if (cnt == RESP_LAST) begin
                            state             <= RX_IDLE;
                            responseTimeout_o <= 1'b1;
                        end
                    end
                    USB_RST: state <= RX_IDLE;
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_sie_phase_ctrl.sv
// tb_usb_sie_phase_ctrl: directed and randomized self-checking bench for usb_sie_phase_ctrl.
module tb_usb_sie_phase_ctrl;
    localparam int GAP = 8;
    localparam int TO  = 72;

    logic       clk48_i = 1'b0;
    logic       rst_n_i;
    logic       sendReq_i;
    logic       expectResponse_i;
    logic       sendAck_o;
    logic       sendDone_o;
    logic       sendAborted_o;
    logic       responseTimeout_o;
    logic       rxPacketDone_o;
    logic       isSendingPhase_o;
    logic       txReqSendPacket_o;
    logic       txDoneSending_i;
    logic       rxDataValid_i;
    logic       rxIsLastByte_i;
    logic       rxAcceptNewData_i;
    logic       usbResetDetected_i;
    logic       ackUsbResetDetect_o;
    logic [2:0] state_o;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    usb_sie_phase_ctrl #(.TX_GAP_CYCLES(GAP), .RESP_TIMEOUT_CYCLES(TO)) dut (
        .clk48_i(clk48_i),
        .rst_n_i(rst_n_i),
        .sendReq_i(sendReq_i),
        .expectResponse_i(expectResponse_i),
        .sendAck_o(sendAck_o),
        .sendDone_o(sendDone_o),
        .sendAborted_o(sendAborted_o),
        .responseTimeout_o(responseTimeout_o),
        .rxPacketDone_o(rxPacketDone_o),
        .isSendingPhase_o(isSendingPhase_o),
        .txReqSendPacket_o(txReqSendPacket_o),
        .txDoneSending_i(txDoneSending_i),
        .rxDataValid_i(rxDataValid_i),
        .rxIsLastByte_i(rxIsLastByte_i),
        .rxAcceptNewData_i(rxAcceptNewData_i),
        .usbResetDetected_i(usbResetDetected_i),
        .ackUsbResetDetect_o(ackUsbResetDetect_o),
        .state_o(state_o)
    );

    assign outs = {sendAck_o, sendDone_o, sendAborted_o, responseTimeout_o, rxPacketDone_o,
                   isSendingPhase_o, txReqSendPacket_o, ackUsbResetDetect_o, state_o};

    always #10 clk48_i = ~clk48_i;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk48_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called right after the edge that entered the gap; runs through to TX_ACTIVE.
    task automatic txFromGap(input string tag);
        int n;
        chk({tag, ".gapState"}, state_o, 2);
        chk({tag, ".gapSending"}, isSendingPhase_o, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sendAck_o && n < GAP + 20);
        chk({tag, ".ackLatency"}, n, GAP);
        chk({tag, ".txReq"}, txReqSendPacket_o, 1);
        chk({tag, ".reqState"}, state_o, 3);
        tick();
        sendReq_i = 1'b0;
        expectResponse_i = 1'b0;
        chk({tag, ".ackPulse"}, {sendAck_o, txReqSendPacket_o}, 0);
        chk({tag, ".activeState"}, state_o, 4);
    endtask

    task automatic startTx(input string tag, input bit e);
        sendReq_i = 1'b1;
        expectResponse_i = e;
        tick();
        txFromGap(tag);
    endtask

    task automatic finishTx(input string tag, input bit e);
        txDoneSending_i = 1'b1;
        tick();
        txDoneSending_i = 1'b0;
        chk({tag, ".sendDone"}, sendDone_o, 1);
        chk({tag, ".sendingOff"}, isSendingPhase_o, 0);
        chk({tag, ".doneState"}, state_o, e ? 5 : 0);
    endtask

    // Already in RX_ACTIVE with valid high; consume L bytes with random stalls.
    task automatic rxBody(input string tag, input int len);
        int  bytes = 0;
        int  k = 0;
        bit  acc;
        bit  done;
        rxDataValid_i = 1'b1;
        while (bytes < len && k < 64) begin
            acc = ($urandom_range(0, 2) != 0);
            rxAcceptNewData_i = acc;
            rxIsLastByte_i = (bytes == len - 1);
            tick();
            k++;
            done = acc && (bytes == len - 1);
            if (acc) bytes++;
            chk({tag, ".rxDone"}, rxPacketDone_o, done);
            chk({tag, ".rxState"}, state_o, done ? 0 : 1);
        end
        rxDataValid_i = 1'b0;
        rxAcceptNewData_i = 1'b0;
        rxIsLastByte_i = 1'b0;
        chk({tag, ".rxBytes"}, bytes, len);
    endtask

    // In WAIT_RESP; response first seen on edge d after entry (d > TO means none).
    task automatic respPhase(input string tag, input int d);
        int toAt = 0;
        int lim;
        lim = (d < TO) ? d : TO;
        for (int k = 1; k <= lim; k++) begin
            rxDataValid_i = (k == d);
            tick();
            if (responseTimeout_o) toAt = k;
        end
        chk({tag, ".timeoutAt"}, toAt, (d > TO) ? TO : 0);
        chk({tag, ".respState"}, state_o, (d <= TO) ? 1 : 0);
        if (d <= TO) rxBody(tag, $urandom_range(1, 5));
        else rxDataValid_i = 1'b0;
    endtask

    initial begin
        int d;
        int kind;
        rst_n_i = 1'b0;
        sendReq_i = 1'b0;
        expectResponse_i = 1'b0;
        txDoneSending_i = 1'b0;
        rxDataValid_i = 1'b0;
        rxIsLastByte_i = 1'b0;
        rxAcceptNewData_i = 1'b0;
        usbResetDetected_i = 1'b0;
        #1;
        chk("rst.outs", outs, 0);
        repeat (3) tick();
        chk("rst.held", outs, 0);
        rst_n_i = 1'b1;
        tick();
        chk("rst.idle", outs, 0);

        // plain send, no response expected
        startTx("send0", 1'b0);
        repeat (3) begin
            tick();
            chk("send0.activeHold", state_o, 4);
        end
        finishTx("send0", 1'b0);
        tick();
        chk("send0.donePulse", sendDone_o, 0);

        // send expecting a response that never comes
        startTx("toFull", 1'b1);
        finishTx("toFull", 1'b1);
        respPhase("toFull", 1000);

        // response arrives at cycle 40
        startTx("resp40", 1'b1);
        finishTx("resp40", 1'b1);
        respPhase("resp40", 40);

        // response on the terminal timeout cycle
        startTx("tie", 1'b1);
        finishTx("tie", 1'b1);
        respPhase("tie", TO);

        // RX and send request in the same idle cycle
        rxDataValid_i = 1'b1;
        sendReq_i = 1'b1;
        tick();
        chk("coll.rxState", state_o, 1);
        chk("coll.notSending", isSendingPhase_o, 0);
        repeat (3) begin
            tick();
            chk("coll.rxHold", state_o, 1);
        end
        rxAcceptNewData_i = 1'b1;
        rxIsLastByte_i = 1'b1;
        tick();
        rxDataValid_i = 1'b0;
        rxAcceptNewData_i = 1'b0;
        rxIsLastByte_i = 1'b0;
        chk("coll.rxDone", rxPacketDone_o, 1);
        chk("coll.idle", state_o, 0);
        tick();
        txFromGap("coll");
        finishTx("coll", 1'b0);

        // USB reset during TX_ACTIVE
        startTx("ures", 1'b0);
        usbResetDetected_i = 1'b1;
        tick();
        chk("ures.aborted", sendAborted_o, 1);
        chk("ures.ack", ackUsbResetDetect_o, 1);
        chk("ures.sending", isSendingPhase_o, 0);
        chk("ures.state", state_o, 6);
        tick();
        chk("ures.pulses", {sendAborted_o, ackUsbResetDetect_o}, 0);
        chk("ures.stay", state_o, 6);
        usbResetDetected_i = 1'b0;
        tick();
        chk("ures.release", state_o, 0);

        // asynchronous reset in the middle of the gap
        sendReq_i = 1'b1;
        tick();
        tick();
        tick();
        chk("arst.pre", isSendingPhase_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst.outs", outs, 0);
        tick();
        tick();
        chk("arst.held", outs, 0);
        rst_n_i = 1'b1;
        tick();
        txFromGap("arst");
        finishTx("arst", 1'b0);

        // randomized transactions against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd.idle", state_o, 0);
            end
            if (kind == 0) begin
                rxDataValid_i = 1'b1;
                sendReq_i = $urandom_range(0, 1);
                tick();
                sendReq_i = 1'b0;
                chk("rnd.rxStart", state_o, 1);
                rxBody("rnd", $urandom_range(1, 6));
            end else begin
                startTx("rnd", kind == 2);
                repeat ($urandom_range(0, 10)) begin
                    tick();
                    chk("rnd.txHold", {sendDone_o, state_o}, 4);
                end
                finishTx("rnd", kind == 2);
                if (kind == 2) begin
                    d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(1, 110);
                    respPhase("rnd", d);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
